// File: rtl/freq_meas_scheduler.sv
// Round-robin frequency/duty measurement: one shared datapath measures one
// full high phase and the following low phase of each enabled channel in turn.
module freq_meas_scheduler #(
    parameter int NCH     = 4,
    parameter int CW      = 20,
    parameter int TIMEOUT = 1000000
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [NCH-1:0]          IN,
    input  logic                    EN,
    input  logic [NCH-1:0]          CH_MASK,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [$clog2(NCH)-1:0]  res_chan,
    output logic [CW-1:0]           on_count,
    output logic [CW-1:0]           off_count,
    output logic                    res_timeout,
    output logic                    busy
);

    localparam int PW = $clog2(NCH);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CMAX = '1;

    typedef enum logic [2:0] {IDLE, SELECT, ARM, HIGH, LOW, REPORT} state_t;

    state_t          state_q, state_d;
    logic [NCH-1:0]  sync1_q, sync2_q;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic            prev_q, prev_d;
    logic [CW-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [PW-1:0]   chan_q, chan_d;
    logic [CW-1:0]   on_q, on_d, off_q, off_d;
    logic            to_q, to_d;

    logic [NCH-1:0]  s;
    logic            s_cur;
    logic            timed_out;
    logic            sel_found;
    logic [PW-1:0]   sel_idx;
    logic [PW-1:0]   cand;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == CMAX) ? v : v + CW'(1);
    endfunction

    assign s         = sync2_q;
    assign s_cur     = s[ptr_q];
    assign timed_out = (timer_q == TW'(TIMEOUT));

    // Next enabled channel after ptr, wrapping; ptr itself is tried last.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = ptr_q;
        cand      = ptr_q;
        for (int k = 1; k <= NCH; k++) begin
            cand = PW'((int'(ptr_q) + k) % NCH);
            if (!sel_found && CH_MASK[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // NOTE: every signal gets its default before the case so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        prev_d  = prev_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        timer_d = timer_q;
        chan_d  = chan_q;
        on_d    = on_q;
        off_d   = off_q;
        to_d    = to_q;
        case (state_q)
            IDLE: begin
                if (EN && (|CH_MASK)) state_d = SELECT;
            end
            SELECT: begin
                if (sel_found) begin
                    ptr_d   = sel_idx;
                    prev_d  = s[sel_idx];
                    hi_d    = '0;
                    lo_d    = '0;
                    timer_d = '0;
                    state_d = ARM;
                end else begin
                    state_d = IDLE;
                end
            end
            ARM, HIGH, LOW: begin
                timer_d = timer_q + TW'(1);
                if (timed_out) begin
                    chan_d  = ptr_q;
                    on_d    = '0;
                    off_d   = '0;
                    to_d    = 1'b1;
                    state_d = REPORT;
                end else if (state_q == ARM) begin
                    prev_d = s_cur;
                    if (s_cur && !prev_q) begin
                        hi_d    = CW'(1);
                        state_d = HIGH;
                    end
                end else if (state_q == HIGH) begin
                    if (s_cur) begin
                        hi_d = sat_inc(hi_q);
                    end else begin
                        lo_d    = CW'(1);
                        state_d = LOW;
                    end
                end else begin
                    if (!s_cur) begin
                        lo_d = sat_inc(lo_q);
                    end else begin
                        chan_d  = ptr_q;
                        on_d    = hi_q;
                        off_d   = lo_q;
                        to_d    = 1'b0;
                        state_d = REPORT;
                    end
                end
            end
            REPORT: begin
                if (res_ready) state_d = (EN && (|CH_MASK)) ? SELECT : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            sync1_q <= '0;
            sync2_q <= '0;
            ptr_q   <= PW'(NCH - 1);
            prev_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            timer_q <= '0;
            chan_q  <= '0;
            on_q    <= '0;
            off_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= IN;
            sync2_q <= sync1_q;
            ptr_q   <= ptr_d;
            prev_q  <= prev_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            timer_q <= timer_d;
            chan_q  <= chan_d;
            on_q    <= on_d;
            off_q   <= off_d;
            to_q    <= to_d;
        end
    end

    assign res_valid   = (state_q == REPORT);
    assign busy        = (state_q != IDLE);
    assign res_chan    = chan_q;
    assign on_count    = on_q;
    assign off_count   = off_q;
    assign res_timeout = to_q;

endmodule

// File: tb/tb_freq_meas_scheduler.sv
// Scoreboard bench for freq_meas_scheduler: directed waveforms per channel,
// expected results queued at stimulus time and checked by a handshake monitor.
module tb_freq_meas_scheduler;

    localparam int NCH     = 4;
    localparam int CW      = 4;
    localparam int TIMEOUT = 100;

    logic            CLK = 1'b0;
    logic            RST;
    logic [NCH-1:0]  IN;
    logic            EN;
    logic [NCH-1:0]  CH_MASK;
    logic            res_valid;
    logic            res_ready;
    logic [1:0]      res_chan;
    logic [CW-1:0]   on_count;
    logic [CW-1:0]   off_count;
    logic            res_timeout;
    logic            busy;

    typedef struct packed {
        logic [1:0] chan;
        logic [3:0] on;
        logic [3:0] off;
        logic       to;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_pop = 0;

    logic wave_mode [NCH];
    logic wave_lvl  [NCH];
    int   wave_h    [NCH];
    int   wave_l    [NCH];

    freq_meas_scheduler #(.NCH(NCH), .CW(CW), .TIMEOUT(TIMEOUT)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .IN          (IN),
        .EN          (EN),
        .CH_MASK     (CH_MASK),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_chan    (res_chan),
        .on_count    (on_count),
        .off_count   (off_count),
        .res_timeout (res_timeout),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] v, input logic [31:0] c,
                             input logic [31:0] on, input logic [31:0] off,
                             input logic [31:0] to, input logic [31:0] b);
        check({tag, ".res_valid"},   32'(res_valid),   v);
        check({tag, ".res_chan"},    32'(res_chan),    c);
        check({tag, ".on_count"},    32'(on_count),    on);
        check({tag, ".off_count"},   32'(off_count),   off);
        check({tag, ".res_timeout"}, 32'(res_timeout), to);
        check({tag, ".busy"},        32'(busy),        b);
    endtask

    task automatic push(input logic [1:0] c, input logic [3:0] on, input logic [3:0] off,
                        input logic to);
        exp_t e;
        e.chan = c;
        e.on   = on;
        e.off  = off;
        e.to   = to;
        sb_q.push_back(e);
    endtask

    task automatic set_wave(input int ch, input int h, input int l);
        wave_h[ch]    = h;
        wave_l[ch]    = l;
        wave_mode[ch] = 1'b1;
    endtask

    task automatic set_level(input int ch, input logic v);
        wave_mode[ch] = 1'b0;
        wave_lvl[ch]  = v;
    endtask

    // Leaves the synchronizers settled to the live inputs before returning.
    task automatic do_reset();
        RST = 1'b1;
        EN  = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
    endtask

    // Returns just after the negedge on which the target handshake was seen.
    task automatic wait_pops(input string name, input int target, input int budget);
        int cyc = 0;
        while (n_pop < target && cyc < budget) begin
            @(negedge CLK);
            #1;
            cyc++;
        end
        check(name, 32'(n_pop), 32'(target));
    endtask

    // Waveform generator: the only driver of IN; restarts a wave at its high phase.
    initial begin
        int   cnt  [NCH];
        logic prev [NCH];
        IN = '0;
        for (int i = 0; i < NCH; i++) begin
            cnt[i]  = 0;
            prev[i] = 1'b0;
        end
        forever begin
            @(posedge CLK);
            #2;
            for (int i = 0; i < NCH; i++) begin
                if (!wave_mode[i]) begin
                    IN[i] = wave_lvl[i];
                end else begin
                    if (!prev[i]) cnt[i] = 0;
                    IN[i]  = (cnt[i] < wave_h[i]);
                    cnt[i] = (cnt[i] + 1 == wave_h[i] + wave_l[i]) ? 0 : cnt[i] + 1;
                end
                prev[i] = wave_mode[i];
            end
        end
    end

    // Monitor: every accepted result is compared against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RST && res_valid && res_ready) begin
                n_pop++;
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_result: got chan %0d on %0d off %0d to %0d, expected none",
                             res_chan, on_count, off_count, res_timeout);
                end else begin
                    e = sb_q.pop_front();
                    check("res_chan",    32'(res_chan),    32'(e.chan));
                    check("on_count",    32'(on_count),    32'(e.on));
                    check("off_count",   32'(off_count),   32'(e.off));
                    check("res_timeout", 32'(res_timeout), 32'(e.to));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        RST       = 1'b1;
        EN        = 1'b0;
        res_ready = 1'b0;
        CH_MASK   = '0;
        for (int i = 0; i < NCH; i++) begin
            set_level(i, 1'b0);
            wave_h[i] = 1;
            wave_l[i] = 1;
        end
        repeat (3) @(posedge CLK);
        #1;
        check_all("reset", 0, 0, 0, 0, 0, 0);
        RST = 1'b0;

        // Single channel, 5 high / 3 low, back to back.
        set_wave(0, 5, 3);
        CH_MASK   = 4'b0001;
        res_ready = 1'b1;
        EN        = 1'b1;
        repeat (3) push(2'd0, 4'd5, 4'd3, 1'b0);
        wait_pops("single_done", 3, 200);
        EN = 1'b0;
        @(posedge CLK);
        #1;
        check("single_idle_busy", 32'(busy), 0);

        // Round robin over channels 0,1,3; channel 2 toggles but is masked.
        do_reset();
        set_wave(1, 2, 4);
        set_wave(2, 3, 3);
        set_wave(3, 7, 6);
        CH_MASK = 4'b1011;
        EN      = 1'b1;
        for (int r = 0; r < 2; r++) begin
            push(2'd0, 4'd5, 4'd3, 1'b0);
            push(2'd1, 4'd2, 4'd4, 1'b0);
            push(2'd3, 4'd7, 4'd6, 1'b0);
        end
        wait_pops("rr_done", 9, 400);
        EN = 1'b0;

        // Channel 2 stuck high: timeout, then outputs held while not ready.
        set_level(2, 1'b1);
        do_reset();
        CH_MASK   = 4'b0100;
        res_ready = 1'b0;
        EN        = 1'b1;
        push(2'd2, 4'd0, 4'd0, 1'b1);
        lat = 0;
        while (!res_valid && lat < 300) begin
            @(posedge CLK);
            #1;
            lat++;
        end
        check("timeout_latency", 32'(lat), 103);
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK);
            #1;
            check("timeout_hold", 32'({res_valid, res_chan, on_count, off_count, res_timeout}),
                  32'({1'b1, 2'd2, 4'd0, 4'd0, 1'b1}));
        end
        res_ready = 1'b1;
        wait_pops("timeout_done", 10, 5);
        EN = 1'b0;

        // 40-cycle high phase saturates the 4-bit on_count.
        set_level(1, 1'b0);
        set_level(2, 1'b0);
        do_reset();
        CH_MASK = 4'b0010;
        EN      = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        set_wave(1, 40, 10);
        push(2'd1, 4'd15, 4'd10, 1'b0);
        wait_pops("sat_done", 11, 150);
        EN = 1'b0;

        // EN dropped during HIGH: result still delivered, then IDLE.
        set_level(0, 1'b0);
        do_reset();
        CH_MASK = 4'b0001;
        EN      = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        set_wave(0, 12, 4);
        repeat (6) @(posedge CLK);
        #1;
        EN = 1'b0;
        push(2'd0, 4'd12, 4'd4, 1'b0);
        wait_pops("en_drop_done", 12, 100);
        @(posedge CLK);
        #1;
        check("en_drop_busy",  32'(busy),      0);
        check("en_drop_valid", 32'(res_valid), 0);

        // Reset in the second cycle of LOW discards the measurement.
        set_level(0, 1'b0);
        repeat (3) @(posedge CLK);
        #1;
        EN = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        set_wave(0, 12, 4);
        repeat (16) @(posedge CLK);
        #1;
        check("pre_rst_busy", 32'(busy), 1);
        RST = 1'b1;
        EN  = 1'b0;
        @(posedge CLK);
        #1;
        check_all("rst_mid_low", 0, 0, 0, 0, 0, 0);
        RST = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        check("sb_empty", 32'(sb_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/freq_meas_scheduler.md
# freq_meas_scheduler

Multi-channel frequency/duty measurement controller. Synchronizes up to NCH asynchronous input signals, selects one enabled channel at a time in round-robin order, measures one complete high phase and the following low phase in CLK cycles, and returns each result through a valid/ready handshake. It sits between the raw signal pins and the register/report logic, time-sharing a single measurement datapath across all channels.

## Interface
- NCH, 4: number of input channels (2..16).
- CW, 20: width of on/off count results.
- TIMEOUT, 1000000: cycles allowed per measurement, counted from ARM entry, before abort.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- IN  in  NCH  raw asynchronous signals, one bit per channel.
- EN  in  1  run enable; sweeps continue while high.
- CH_MASK  in  NCH  1 = channel participates in round-robin.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_chan  out  clog2(NCH)  channel the result belongs to.
- on_count  out  CW  measured high-phase length, cycles.
- off_count  out  CW  measured low-phase length, cycles.
- res_timeout  out  1  measurement aborted by timeout; counts are 0.
- busy  out  1  high in any state except IDLE.

## Operation
- Each IN bit passes through a 2-flop synchronizer; s[i] is the synchronized value. Measurement logic sees only s.
- FSM states: IDLE, SELECT, ARM, HIGH, LOW, REPORT.
- IDLE: if EN and CH_MASK != 0, go to SELECT; else stay.
- SELECT (1 cycle): pick the first channel with mask bit set, searching upward with wrap from ptr+1; ptr := that channel. Clear hi/lo counters and timer; load prev := s[ptr]. Go to ARM.
- ARM: wait for a rising edge (s[ptr]=1 and prev=0). On the edge cycle set hi=1 and go to HIGH. A channel already high at selection must first go low, then high.
- HIGH: s=1 -> hi+1; s=0 -> lo=1, go to LOW.
- LOW: s=0 -> lo+1; s=1 (next rising edge) -> latch results, go to REPORT. The edge cycle is not counted.
- Counters saturate at 2^CW-1; no wrap.
- Timer increments every cycle in ARM/HIGH/LOW. When it reaches TIMEOUT, go to REPORT with res_timeout=1, on_count=off_count=0. Timeout has priority over an edge detected in the same cycle.
- REPORT: res_valid=1; res_chan, on_count, off_count, res_timeout held stable until res_ready. On the handshake cycle (valid and ready), go to SELECT if EN and CH_MASK != 0, else IDLE.
- Deasserting EN or changing CH_MASK mid-measurement does not abort. The current channel completes and reports; the new values are sampled only at the REPORT exit and in IDLE.
- If the mask selects a single channel, that channel is re-measured back to back.

## Timing
- Reset: state=IDLE, ptr=NCH-1 (so channel 0 is served first), synchronizers=0, prev=0, res_valid=0, res_chan=0, on_count=0, off_count=0, res_timeout=0, busy=0.
- Reset mid-measurement or mid-REPORT discards everything; res_valid drops the next cycle.
- Raw IN edge to s edge: 2 cycles.
- For a stable periodic s with H high cycles and L low cycles, the result is on_count=H, off_count=L.
- res_valid rises the cycle after the terminating rising edge of s.
- Result outputs update only on REPORT entry and are stable while res_valid=1.
- Handshake to SELECT: 1 cycle; SELECT to ARM: 1 cycle.
- res_ready held high permanently still requires 1 REPORT cycle per result.
- res_ready asserted while res_valid=0 has no effect.

## Test plan
- Reset, EN=1, CH_MASK=4'b0001, IN[0] square wave 5 high / 3 low -> res_chan=0, on=5, off=3, timeout=0; repeats each period while res_ready=1.
- CH_MASK=4'b1011, distinct waves per channel, res_ready=1 -> result order 0,1,3,0,1,3; each result matches its channel's H/L.
- IN[2] stuck high, CH_MASK=4'b0100, TIMEOUT=100 -> res_valid rises 101 cycles after ARM entry with timeout=1, on=0, off=0.
- res_ready=0 for 20 cycles after res_valid -> outputs frozen throughout; FSM advances only on the handshake.
- CW=4, high phase of 40 cycles -> on_count=15 (saturated).
- Deassert EN during HIGH -> current result still reported, then IDLE with busy=0; assert RST mid-LOW -> all outputs are the reset values on the next cycle.
